// File: rtl/time_display.sv
// Wall-clock time bus consumer: captures hour/min/sec, converts each field to BCD
// with a subtract-10 FSM, and scans a 6-digit multiplexed 7-segment display HH.MM.SS.
module time_display #(
   parameter int SCAN_DIV   = 50000,
   parameter bit BLANK_LZ   = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] hour,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic       dot,
   input  logic       valid,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       busy
);

   localparam int         PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   function automatic logic [6:0] bcd_to_seg(input logic [5:0] d);
      logic [6:0] s;
      case (d)
         6'd0:    s = 7'h3F;
         6'd1:    s = 7'h06;
         6'd2:    s = 7'h5B;
         6'd3:    s = 7'h4F;
         6'd4:    s = 7'h66;
         6'd5:    s = 7'h6D;
         6'd6:    s = 7'h7D;
         6'd7:    s = 7'h07;
         6'd8:    s = 7'h7F;
         6'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] pol7(input logic [6:0] v);
      return ACTIVE_LOW ? ~v : v;
   endfunction

   function automatic logic [5:0] pol6(input logic [5:0] v);
      return ACTIVE_LOW ? ~v : v;
   endfunction

   function automatic logic pol1(input logic v);
      return ACTIVE_LOW ? ~v : v;
   endfunction

   // Returns {tens_code, ones_code} for one field, active-high.
   function automatic logic [13:0] field_codes(input logic bad, input logic [2:0] tens,
                                                input logic [5:0] rem, input logic lz_blank);
      logic [6:0] t, o;
      if (bad) begin
         t = SEG_DASH;
         o = SEG_DASH;
      end else begin
         t = (lz_blank && tens == 3'd0) ? SEG_BLANK : bcd_to_seg({3'b000, tens});
         o = bcd_to_seg(rem);
      end
      return {t, o};
   endfunction

   state_t      state;
   logic [2:0]  cnt;
   logic        busy_q;
   logic [5:0]  rem_p1  [3];   // index 0 = sec, 1 = min, 2 = hour
   logic [2:0]  tens_p1 [3];
   logic        bad_p1  [3];
   logic [6:0]  disp_p2 [6];   // active-high codes; index 0 = sec ones .. 5 = hour tens
   logic        dot_p1;
   logic [PW-1:0] presc;
   logic [2:0]  idx;
   logic [6:0]  seg_p3;
   logic [5:0]  an_p3;
   logic        dp_p3;

   logic [13:0] sec_codes, min_codes, hour_codes;

   always_comb begin
      sec_codes  = field_codes(bad_p1[0], tens_p1[0], rem_p1[0], 1'b0);
      min_codes  = field_codes(bad_p1[1], tens_p1[1], rem_p1[1], 1'b0);
      hour_codes = field_codes(bad_p1[2], tens_p1[2], rem_p1[2], BLANK_LZ);
   end

   // Stage 1: capture and iterative BCD conversion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         busy_q <= 1'b0;
         for (int f = 0; f < 3; f++) begin
            rem_p1[f]  <= 6'd0;
            tens_p1[f] <= 3'd0;
            bad_p1[f]  <= 1'b0;
         end
         for (int d = 0; d < 6; d++) disp_p2[d] <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  rem_p1[0] <= sec;
                  rem_p1[1] <= min;
                  rem_p1[2] <= {1'b0, hour};
                  bad_p1[0] <= (sec > 6'd59);
                  bad_p1[1] <= (min > 6'd59);
                  bad_p1[2] <= (hour > 5'd23);
                  for (int f = 0; f < 3; f++) tens_p1[f] <= 3'd0;
                  cnt    <= 3'd0;
                  busy_q <= 1'b1;
                  state  <= CONV;
               end
            end
            CONV: begin
               for (int f = 0; f < 3; f++) begin
                  if (rem_p1[f] >= 6'd10) begin
                     rem_p1[f]  <= rem_p1[f] - 6'd10;
                     tens_p1[f] <= tens_p1[f] + 3'd1;
                  end
               end
               cnt <= cnt + 3'd1;
               if (cnt == 3'd5) state <= DONE;
            end
            DONE: begin
               // Stage 2: commit all six digits at once
               {disp_p2[1], disp_p2[0]} <= sec_codes;
               {disp_p2[3], disp_p2[2]} <= min_codes;
               {disp_p2[5], disp_p2[4]} <= hour_codes;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Stage 3: digit scan and registered pin drivers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dot_p1 <= 1'b0;
         presc  <= '0;
         idx    <= 3'd0;
         an_p3  <= pol6(6'b000001);
         seg_p3 <= pol7(SEG_BLANK);
         dp_p3  <= pol1(1'b0);
      end else begin
         dot_p1 <= dot;
         if (presc == PRE_LAST) begin
            presc <= '0;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end else begin
            presc <= presc + 1'b1;
         end
         an_p3  <= pol6(6'b000001 << idx);
         seg_p3 <= pol7(disp_p2[idx]);
         dp_p3  <= pol1(dot_p1 && (idx == 3'd2 || idx == 3'd4));
      end
   end

   assign seg  = seg_p3;
   assign an   = an_p3;
   assign dp   = dp_p3;
   assign busy = busy_q;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: reset state, table of time samples with
// hand-computed segment codes, busy timing, decimal points and abort by reset.
module tb_time_display;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       dot;
   logic       valid;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   time_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .hour(hour), .min(min), .sec(sec),
      .dot(dot), .valid(valid), .seg(seg), .dp(dp), .an(an), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      h;
      logic [5:0]      m;
      logic [5:0]      s;
      logic [5:0][6:0] exp;   // [5] = hour tens .. [0] = sec ones, pin-level codes
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic read_digit(input int d, output logic [6:0] s, output logic p);
      logic [5:0] want;
      bit ok;
      want = ~(6'b000001 << d);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (an == want) ok = 1'b1;
      end
      if (!ok) chk($sformatf("scan_timeout_d%0d", d), {26'd0, an}, {26'd0, want});
      s = seg;
      p = dp;
   endtask

   task automatic check_display(input string tag, input logic [5:0][6:0] exp);
      logic [6:0] s;
      logic p;
      for (int d = 0; d < 6; d++) begin
         read_digit(d, s, p);
         chk($sformatf("%s_seg_d%0d", tag, d), {25'd0, s}, {25'd0, exp[d]});
      end
   endtask

   task automatic start_conv(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      @(negedge clk);
      hour = h; min = m; sec = s; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (!busy) done = 1'b1;
         else @(negedge clk);
      end
      if (!done) chk({tag, "_busy_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [6:0] s;
      logic p;
      logic [5:0][6:0] all_blank;
      logic [5:0][6:0] vec_a;

      all_blank = {6{7'h7F}};
      vec_a     = {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00};
      vecs[0] = '{h: 5'd23, m: 6'd59, s: 6'd58, exp: vec_a};
      vecs[1] = '{h: 5'd5,  m: 6'd0,  s: 6'd7,  exp: {7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h78}};
      vecs[2] = '{h: 5'd24, m: 6'd60, s: 6'd63, exp: {6{7'h3F}}};
      vecs[3] = '{h: 5'd12, m: 6'd34, s: 6'd56, exp: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
      vecs[4] = '{h: 5'd0,  m: 6'd0,  s: 6'd0,  exp: {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
      vecs[5] = '{h: 5'd23, m: 6'd59, s: 6'd63, exp: {7'h24, 7'h30, 7'h12, 7'h10, 7'h3F, 7'h3F}};
      vecs[6] = '{h: 5'd19, m: 6'd0,  s: 6'd60, exp: {7'h79, 7'h10, 7'h40, 7'h40, 7'h3F, 7'h3F}};

      reset_n = 1'b0; hour = '0; min = '0; sec = '0; dot = 1'b0; valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an",   {26'd0, an},   32'h3E);
      chk("rst_seg",  {25'd0, seg},  32'h7F);
      chk("rst_dp",   {31'd0, dp},   32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset_n = 1'b1;

      // Idle scan after reset: every digit blank, no decimal point
      for (int d = 0; d < 6; d++) begin
         read_digit(d, s, p);
         chk($sformatf("idle_seg_d%0d", d), {25'd0, s}, 32'h7F);
         chk($sformatf("idle_dp_d%0d", d), {31'd0, p}, 32'd1);
      end

      // Busy high for edges N..N+6 samples, low after N+7
      start_conv(5'd23, 6'd59, 6'd58);
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("busy_cyc%0d", k), {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      check_display("busy_seq", vec_a);

      for (int v = 0; v < 7; v++) begin
         start_conv(vecs[v].h, vecs[v].m, vecs[v].s);
         wait_idle($sformatf("vec%0d", v));
         check_display($sformatf("vec%0d", v), vecs[v].exp);
      end

      // Decimal points on digits 2 and 4 only while dot is high
      @(negedge clk); dot = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 6; d++) begin
         read_digit(d, s, p);
         chk($sformatf("dot1_dp_d%0d", d), {31'd0, p}, (d == 2 || d == 4) ? 32'd0 : 32'd1);
      end
      @(negedge clk); dot = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 6; d++) begin
         read_digit(d, s, p);
         chk($sformatf("dot0_dp_d%0d", d), {31'd0, p}, 32'd1);
      end

      // Second valid while busy is dropped, not queued
      @(negedge clk);
      hour = 5'd23; min = 6'd59; sec = 6'd58; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hour = 5'd5; min = 6'd0; sec = 6'd7; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("ign_busy_n6", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("ign_busy_n7", {31'd0, busy}, 32'd0);
      repeat (10) @(negedge clk);
      chk("ign_no_requeue", {31'd0, busy}, 32'd0);
      check_display("ignored", vec_a);

      // Reset mid-conversion aborts and leaves the display blank
      @(negedge clk);
      hour = 5'd12; min = 6'd34; sec = 6'd56; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hour = 5'd5; min = 6'd0; sec = 6'd7; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_seg",  {25'd0, seg},  32'h7F);
      chk("abort_an",   {26'd0, an},   32'h3E);
      @(negedge clk); reset_n = 1'b1;
      check_display("abort", all_blank);
      chk("abort_busy_post", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
